// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus per-channel stability counter for the slide switches.
// Produces clean levels for the priority encoder and one-cycle change/rise strobes.
module switch_debouncer #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] SW_IN,
  output logic [N_CH-1:0] SW_OUT,
  output logic            CHG,
  output logic [N_CH-1:0] RISE
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [N_CH-1:0]  sync1;
  logic [N_CH-1:0]  sync2;
  logic [CNT_W-1:0] cnt      [N_CH];
  logic [CNT_W-1:0] cnt_next [N_CH];
  logic [N_CH-1:0]  out_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= SW_IN;
      sync2 <= sync1;
    end
  end

  // Any return to agreement clears the count, so only an unbroken run flips the output.
  always_comb begin
    out_next = SW_OUT;
    for (int i = 0; i < N_CH; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != SW_OUT[i]) begin
        if (cnt[i] == CNT_MAX) begin
          out_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SW_OUT <= '0;
      CHG    <= 1'b0;
      RISE   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      SW_OUT <= out_next;
      CHG    <= |(out_next ^ SW_OUT);
      RISE   <= out_next & ~SW_OUT;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomised and directed bench for switch_debouncer; the reference model works from
// a sliding window of synchronised samples rather than from per-channel counters.
module tb_switch_debouncer;

  localparam int N_CH   = 4;
  localparam int STABLE = 8;
  localparam int CNT_W  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N_CH-1:0] SW_IN = '0;
  logic [N_CH-1:0] SW_OUT;
  logic            CHG;
  logic [N_CH-1:0] RISE;

  int checks = 0;
  int errors = 0;

  // Reference model state: raw samples taken at each edge and the window of sync2 values.
  logic [N_CH-1:0] inHist [$];
  logic [N_CH-1:0] s2Hist [$];
  logic [N_CH-1:0] outModel = '0;
  logic [N_CH-1:0] riseModel = '0;
  logic            chgModel = 1'b0;

  int              edgeIdx = 0;
  int              lastChgEdge = -1;
  int              chgPulses = 0;
  logic [N_CH-1:0] riseAccum = '0;
  int              base;

  switch_debouncer #(
    .N_CH(N_CH),
    .STABLE_CYCLES(STABLE),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .SW_IN(SW_IN),
    .SW_OUT(SW_OUT),
    .CHG(CHG),
    .RISE(RISE)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h (edge %0d)", tag, observed, expected, edgeIdx);
    end
  endtask

  task automatic clearModel();
    inHist.delete();
    s2Hist.delete();
    outModel  = '0;
    riseModel = '0;
    chgModel  = 1'b0;
  endtask

  // An output bit flips once the last STABLE synchronised samples all disagree with it.
  task automatic modelEdge(input logic [N_CH-1:0] sample);
    logic [N_CH-1:0] s2;
    logic [N_CH-1:0] prev;
    logic            allDiffer;
    s2 = (inHist.size() >= 2) ? inHist[inHist.size()-2] : '0;
    inHist.push_back(sample);
    if (inHist.size() > 2) void'(inHist.pop_front());
    s2Hist.push_back(s2);
    if (s2Hist.size() > STABLE) void'(s2Hist.pop_front());
    prev = outModel;
    for (int ch = 0; ch < N_CH; ch++) begin
      allDiffer = (s2Hist.size() == STABLE);
      foreach (s2Hist[j]) begin
        if (s2Hist[j][ch] == prev[ch]) allDiffer = 1'b0;
      end
      if (allDiffer) outModel[ch] = ~prev[ch];
    end
    riseModel = outModel & ~prev;
    chgModel  = |(outModel ^ prev);
  endtask

  // Called at a negedge: drive, take one active edge, then compare just after it.
  task automatic applyStimulus(input logic [N_CH-1:0] val);
    SW_IN = val;
    @(posedge clk);
    modelEdge(val);
    #1;
    checkOutput("sw_out", 32'(SW_OUT), 32'(outModel));
    checkOutput("chg", 32'(CHG), 32'(chgModel));
    checkOutput("rise", 32'(RISE), 32'(riseModel));
    if (CHG === 1'b1) begin
      lastChgEdge = edgeIdx;
      chgPulses++;
    end
    riseAccum |= RISE;
    edgeIdx++;
    @(negedge clk);
  endtask

  task automatic holdInput(input logic [N_CH-1:0] val, input int cycles);
    for (int c = 0; c < cycles; c++) applyStimulus(val);
  endtask

  task automatic doReset(input int cycles, input logic [N_CH-1:0] val);
    SW_IN = val;
    rst   = 1'b1;
    #1;
    checkOutput("rst_async_out", 32'(SW_OUT), 32'h0);
    checkOutput("rst_async_chg", 32'(CHG), 32'h0);
    checkOutput("rst_async_rise", 32'(RISE), 32'h0);
    @(negedge clk);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      checkOutput("rst_hold_out", 32'(SW_OUT), 32'h0);
      checkOutput("rst_hold_chg", 32'(CHG), 32'h0);
      checkOutput("rst_hold_rise", 32'(RISE), 32'h0);
      edgeIdx++;
      @(negedge clk);
    end
    rst = 1'b0;
    clearModel();
  endtask

  task automatic startWatch();
    base        = edgeIdx;
    lastChgEdge = -1;
    chgPulses   = 0;
    riseAccum   = '0;
  endtask

  initial begin
    logic [N_CH-1:0] val;
    int              hold;

    @(negedge clk);

    doReset(3, 4'b1111);
    startWatch();
    holdInput(4'b1111, 12);
    checkOutput("rst_release_latency", 32'(lastChgEdge), 32'(base + 9));
    checkOutput("rst_release_pulses", 32'(chgPulses), 32'd1);
    checkOutput("rst_release_rise", 32'(riseAccum), 32'hf);
    checkOutput("rst_release_out", 32'(SW_OUT), 32'hf);

    holdInput(4'b0000, 12);
    startWatch();
    holdInput(4'b0100, 12);
    checkOutput("press_latency", 32'(lastChgEdge), 32'(base + 9));
    checkOutput("press_pulses", 32'(chgPulses), 32'd1);
    checkOutput("press_rise", 32'(riseAccum), 32'h4);
    checkOutput("press_out", 32'(SW_OUT), 32'h4);

    holdInput(4'b0000, 12);
    startWatch();
    holdInput(4'b0001, 5);
    holdInput(4'b0000, 2);
    holdInput(4'b0001, 3);
    holdInput(4'b0000, 10);
    checkOutput("bounce_pulses", 32'(chgPulses), 32'd0);
    checkOutput("bounce_out", 32'(SW_OUT), 32'h0);
    startWatch();
    holdInput(4'b0001, 12);
    checkOutput("bounce_final_latency", 32'(lastChgEdge), 32'(base + 9));
    checkOutput("bounce_final_out", 32'(SW_OUT), 32'h1);

    holdInput(4'b1000, 12);
    checkOutput("release_setup", 32'(SW_OUT), 32'h8);
    startWatch();
    holdInput(4'b0000, 12);
    checkOutput("release_latency", 32'(lastChgEdge), 32'(base + 9));
    checkOutput("release_pulses", 32'(chgPulses), 32'd1);
    checkOutput("release_rise", 32'(riseAccum), 32'h0);
    checkOutput("release_out", 32'(SW_OUT), 32'h0);

    startWatch();
    holdInput(4'b0011, 12);
    checkOutput("simul_latency", 32'(lastChgEdge), 32'(base + 9));
    checkOutput("simul_pulses", 32'(chgPulses), 32'd1);
    checkOutput("simul_rise", 32'(riseAccum), 32'h3);
    checkOutput("simul_out", 32'(SW_OUT), 32'h3);

    holdInput(4'b0000, 12);
    startWatch();
    holdInput(4'b1000, 6);
    checkOutput("midrst_pre_pulses", 32'(chgPulses), 32'd0);
    doReset(1, 4'b1000);
    startWatch();
    holdInput(4'b1000, 12);
    checkOutput("midrst_latency", 32'(lastChgEdge), 32'(base + 9));
    checkOutput("midrst_pulses", 32'(chgPulses), 32'd1);
    checkOutput("midrst_out", 32'(SW_OUT), 32'h8);

    // Mixed segment lengths straddle the flip threshold; occasional resets land mid-count.
    for (int seg = 0; seg < 250; seg++) begin
      val = N_CH'($urandom);
      if ($urandom_range(0, 29) == 0) doReset($urandom_range(1, 3), val);
      hold = ($urandom_range(0, 2) == 0) ? $urandom_range(8, 14) : $urandom_range(1, 9);
      holdInput(val, hold);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
